// File: rtl/reg_file_controller.sv
// Instruction sequencer for a 4x10-bit register file datapath.
// Steps T0 -> T1 (-> T2) and drives the register-file, bus and ALU controls combinationally.
module reg_file_controller (
  input  logic       CLKb,
  input  logic       RST,
  input  logic       Exec,
  input  logic [9:0] INSTR,
  output logic       IRin,
  output logic       EXTRN,
  output logic       ENW,
  output logic [1:0] WRA,
  output logic       ENR0,
  output logic [1:0] RDA0,
  output logic       ENR1,
  output logic [1:0] RDA1,
  output logic       Gin,
  output logic       Gout,
  output logic [3:0] ALUcont,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [1:0] rx, ry;
  logic [3:0] opcode;
  logic       is_alu_op;

  assign rx        = INSTR[9:8];
  assign ry        = INSTR[7:6];
  assign opcode    = INSTR[3:0];
  assign is_alu_op = (opcode[3] == 1'b0) && (opcode[2:1] != 2'b00);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKb) begin
    if (RST) state_q <= T0;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d = T0;
    IRin    = 1'b0;
    EXTRN   = 1'b0;
    ENW     = 1'b0;
    WRA     = 2'b00;
    ENR0    = 1'b0;
    RDA0    = 2'b00;
    ENR1    = 1'b0;
    RDA1    = 2'b00;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ALUcont = 4'b0000;
    Busy    = 1'b0;
    Done    = 1'b0;

    case (state_q)
      T0: begin
        IRin    = Exec;
        state_d = Exec ? T1 : T0;
      end
      T1: begin
        Busy = 1'b1;
        if (opcode == 4'b0000) begin
          EXTRN = 1'b1;
          ENW   = 1'b1;
          WRA   = rx;
          Done  = 1'b1;
        end else if (opcode == 4'b0001) begin
          ENR0 = 1'b1;
          RDA0 = ry;
          ENW  = 1'b1;
          WRA  = rx;
          Done = 1'b1;
        end else if (is_alu_op) begin
          ENR0    = 1'b1;
          RDA0    = rx;
          ENR1    = 1'b1;
          RDA1    = ry;
          ALUcont = opcode;
          Gin     = 1'b1;
          state_d = T2;
        end else begin
          Done = 1'b1;
        end
      end
      T2: begin
        Busy = 1'b1;
        Gout = 1'b1;
        ENW  = 1'b1;
        WRA  = rx;
        Done = 1'b1;
      end
      default: state_d = T0;
    endcase

    // Reset silences every control line, so a pending T2 write is dropped.
    if (RST) begin
      IRin    = 1'b0;
      EXTRN   = 1'b0;
      ENW     = 1'b0;
      WRA     = 2'b00;
      ENR0    = 1'b0;
      RDA0    = 2'b00;
      ENR1    = 1'b0;
      RDA1    = 2'b00;
      Gin     = 1'b0;
      Gout    = 1'b0;
      ALUcont = 4'b0000;
      Busy    = 1'b0;
      Done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_controller.sv
// Self-checking bench for reg_file_controller: directed scenarios then random traffic
// compared against a cycle-position model of the instruction sequence.
module tb_reg_file_controller;

  logic       CLKb = 1'b0;
  logic       RST = 1'b1;
  logic       Exec = 1'b0;
  logic [9:0] INSTR = '0;
  logic       IRin, EXTRN, ENW, ENR0, ENR1, Gin, Gout, Busy, Done;
  logic [1:0] WRA, RDA0, RDA1;
  logic [3:0] ALUcont;

  int checks = 0;
  int errors = 0;
  int pos = 0;            // cycle position inside the current instruction, 0 = T0
  bit prev_enw = 1'b0;

  always #5 CLKb = ~CLKb;

  reg_file_controller dut (
    .CLKb(CLKb), .RST(RST), .Exec(Exec), .INSTR(INSTR),
    .IRin(IRin), .EXTRN(EXTRN), .ENW(ENW), .WRA(WRA),
    .ENR0(ENR0), .RDA0(RDA0), .ENR1(ENR1), .RDA1(RDA1),
    .Gin(Gin), .Gout(Gout), .ALUcont(ALUcont), .Busy(Busy), .Done(Done)
  );

  function automatic bit alu_class(input logic [9:0] ins);
    int op;
    op = int'(ins[3:0]);
    return (op >= 2) && (op <= 7);
  endfunction

  // Expected control word {IRin,EXTRN,ENW,WRA,ENR0,RDA0,ENR1,RDA1,Gin,Gout,ALUcont,Busy,Done}
  function automatic logic [18:0] expected(input int p, input bit rst, input bit ex,
                                           input logic [9:0] ins);
    logic irin, extrn, enw, enr0, enr1, gin, gout, busy, done;
    logic [1:0] wra, rda0, rda1;
    logic [3:0] alu;
    int op;
    {irin, extrn, enw, enr0, enr1, gin, gout, busy, done} = '0;
    {wra, rda0, rda1} = '0;
    alu = '0;
    op = int'(ins[3:0]);
    if (!rst) begin
      if (p == 0) irin = ex;
      else if (p == 1) begin
        busy = 1;
        if (op == 0) begin extrn = 1; enw = 1; wra = ins[9:8]; done = 1; end
        else if (op == 1) begin enr0 = 1; rda0 = ins[7:6]; enw = 1; wra = ins[9:8]; done = 1; end
        else if (alu_class(ins)) begin
          enr0 = 1; rda0 = ins[9:8]; enr1 = 1; rda1 = ins[7:6]; alu = ins[3:0]; gin = 1;
        end else done = 1;
      end else begin
        busy = 1; gout = 1; enw = 1; wra = ins[9:8]; done = 1;
      end
    end
    return {irin, extrn, enw, wra, enr0, rda0, enr1, rda1, gin, gout, alu, busy, done};
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check outputs, then advance the model.
  task automatic step(input string tag, input bit rst, input bit ex, input logic [9:0] ins);
    logic [18:0] obs;
    int drivers;
    @(negedge CLKb);
    RST = rst; Exec = ex; INSTR = ins;
    #1;
    obs = {IRin, EXTRN, ENW, WRA, ENR0, RDA0, ENR1, RDA1, Gin, Gout, ALUcont, Busy, Done};
    check(tag, obs, expected(pos, rst, ex, ins));
    drivers = int'(EXTRN) + int'(Gout) + int'(ENR0 && !Gin);
    check({tag, "_bus1hot"}, {18'd0, drivers <= 1}, 19'd1);
    check({tag, "_enw2x"}, {18'd0, prev_enw && ENW}, 19'd0);
    prev_enw = ENW;
    if (rst) pos = 0;
    else if (pos == 0) pos = ex ? 1 : 0;
    else if (pos == 1) pos = alu_class(ins) ? 2 : 0;
    else pos = 0;
  endtask

  initial begin
    logic [9:0] ins;
    bit ex;
    // Reset held with Exec high
    step("rst0", 1, 1, 10'b10_00_00_0000);
    step("rst1", 1, 1, 10'b10_00_00_0000);
    // LOAD Rx=2
    step("load_t0", 0, 1, 10'b10_00_00_0000);
    step("load_t1", 0, 0, 10'b10_00_00_0000);
    step("load_idle", 0, 0, 10'b10_00_00_0000);
    // ADD Rx=1 Ry=3
    step("add_t0", 0, 1, 10'b01_11_00_0010);
    step("add_t1", 0, 0, 10'b01_11_00_0010);
    step("add_t2", 0, 0, 10'b01_11_00_0010);
    step("add_idle", 0, 0, 10'b01_11_00_0010);
    // Reserved opcode, Exec held high
    for (int i = 0; i < 6; i++) step("rsvd_b2b", 0, 1, 10'b00_00_00_1010);
    step("rsvd_end", 0, 0, 10'b00_00_00_1010);
    step("rsvd_idle", 0, 0, 10'b00_00_00_1010);
    // SUB with reset in T1, then clean restart
    step("sub_t0", 0, 1, 10'b11_01_00_0011);
    step("sub_rst", 1, 0, 10'b11_01_00_0011);
    step("sub_after", 0, 0, 10'b11_01_00_0011);
    step("sub2_t0", 0, 1, 10'b11_01_00_0011);
    step("sub2_t1", 0, 0, 10'b11_01_00_0011);
    step("sub2_t2", 0, 0, 10'b11_01_00_0011);
    // COPY Rx=Ry=0
    step("copy_t0", 0, 1, 10'b00_00_00_0001);
    step("copy_t1", 0, 0, 10'b00_00_00_0001);
    step("copy_idle", 0, 0, 10'b00_00_00_0001);
    // Random traffic; INSTR only changes while the model is in T0
    ins = 10'($urandom);
    for (int i = 0; i < 400; i++) begin
      if (pos == 0) ins = 10'($urandom);
      ex = ($urandom_range(0, 2) != 0);
      step("rand", ($urandom_range(0, 19) == 0), ex, ins);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_controller.md
# reg_file_controller

Instruction sequencer that drives the 4×10-bit register file's write port (ENW/WRA) and two read ports (ENR0/RDA0, ENR1/RDA1), plus the datapath bus and ALU controls around it. It fetches a 10-bit instruction into the instruction register, decodes it, and steps T0→T1(→T2) to complete load, copy and ALU operations. It is the initiator for every register-file transaction in the processor datapath.

## Interface

- No parameters. Data width is 10, register count is 4, and opcode width is 4; all are fixed.

- CLKb  in  1  system clock, rising-edge
- RST  in  1  synchronous, active-high reset
- Exec  in  1  start request, level-sensitive, sampled in T0
- INSTR  in  10  instruction register contents: [9:8]=Rx, [7:6]=Ry, [5:4] unused, [3:0]=opcode
- IRin  out  1  load instruction register from data bus
- EXTRN  out  1  drive external data onto bus
- ENW  out  1  register file write enable
- WRA  out  2  register file write address
- ENR0  out  1  read port 0 enable; Q0 drives bus / ALU A
- RDA0  out  2  read port 0 address
- ENR1  out  1  read port 1 enable; Q1 feeds ALU B
- RDA1  out  2  read port 1 address
- Gin  out  1  latch ALU result into G register
- Gout  out  1  drive G onto bus
- ALUcont  out  4  ALU operation select
- Busy  out  1  high in T1/T2
- Done  out  1  final cycle of an instruction

## Operation

- State register: T0 (idle/fetch), T1, T2. Encoding is free; there is no unused-state lockup, and any illegal state goes to T0.
- All outputs are combinational from the state and INSTR. Every output not listed for a state is 0, and all address outputs default to 2'b00.
- **T0**
  - IRin = Exec.
  - If Exec = 1, go to T1; otherwise stay in T0.
- **T1**, decoded from INSTR[3:0]:
  - 0000 LOAD: EXTRN=1, ENW=1, WRA=Rx, Done=1. Next state T0.
  - 0001 COPY: ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, Done=1. Next state T0.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT:
    - ENR0=1, RDA0=Rx, ENR1=1, RDA1=Ry, ALUcont=INSTR[3:0], Gin=1.
    - Next state T2.
  - 1000–1111 (reserved): Done=1 with no writes and no reads. Next state T0.
- **T2** (ALU ops only): Gout=1, ENW=1, WRA=Rx, Done=1. Next state T0.
- Busy = 1 in T1 and T2.
- Rx may equal Ry; no special handling is required. The register file reads the old value in T1, and the write lands at the end of T2.
- Exec is ignored outside T0. INSTR must stay stable from the T0 fetch edge through Done. The controller does not latch INSTR itself.

## Timing

- **Reset**
  - RST=1 at a rising edge of CLKb forces the state to T0.
  - While RST=1, every output is forced to 0, including IRin, whatever Exec is.
- **Reset mid-instruction** (T1 or T2):
  - The next state is T0.
  - No ENW or Done is issued in the cycle after the reset edge.
  - A write pending in T2 is discarded.
- **Latency**, counted from T0 with Exec=1:
  - LOAD, COPY and reserved opcodes: 2 cycles; Done in cycle 2.
  - ALU ops: 3 cycles; Done in cycle 3.
- **Back-to-back:** Exec held high gives a new fetch on the cycle after Done. There is no dead cycle between instructions other than T0.
- **One-hot guarantees:**
  - ENW is never high in two consecutive cycles.
  - At most one of EXTRN, ENR0-as-bus-driver, and Gout is high in any cycle.
  - IRin is never high outside T0.

## Test plan

- **Reset:**
  - Stimulus: RST=1 for 2 cycles with Exec=1.
  - Required: all outputs 0 and state T0. After RST falls with Exec=1, IRin=1 in the first cycle.
- **LOAD:**
  - Stimulus: INSTR=10_00_00_0000 (Rx=2), Exec pulse.
  - Required: T1 has EXTRN=1, ENW=1, WRA=2, Done=1. The next cycle is T0 with all outputs 0.
- **ADD:**
  - Stimulus: INSTR=01_11_00_0010 (Rx=1, Ry=3).
  - Required in T1: ENR0=1, RDA0=1, ENR1=1, RDA1=3, ALUcont=0010, Gin=1, Busy=1.
  - Required in T2: Gout=1, ENW=1, WRA=1, Done=1.
- **Reserved opcode and back-to-back:**
  - Stimulus: INSTR opcode=1010 with Exec held high for 6 cycles.
  - Required: the sequence repeats T0,T1 with Done=1 every second cycle, and ENW stays 0 throughout.
- **Mid-operation reset:**
  - Stimulus: SUB instruction with RST=1 asserted during T1.
  - Required: the next cycle is T0 with no ENW and no Done. The following Exec restarts cleanly from T1.
- **COPY with Rx=Ry=0:**
  - Required in T1: ENR0=1, RDA0=0, ENW=1, WRA=0, Done=1, all in the same cycle.
